// File: rtl/player_inv_pkg.sv
// Shared constants and the Spongent pLayer index function for the inverse permutation layer.
package player_inv_pkg;

  localparam int N_SBOX      = 33;
  localparam int CHUNK_WIDTH = 8;
  localparam int STATE_WIDTH = N_SBOX * CHUNK_WIDTH;

  typedef enum logic {
    IDLE,
    RUN
  } inv_state_t;

  // Forward pLayer destination of bit j; the top bit is a fixed point of the permutation.
  function automatic int p_index(input int j, input int width);
    if (j == width - 1) return width - 1;
    return (j * (width / 4)) % (width - 1);
  endfunction

endpackage

// File: rtl/player_inv_if.sv
// Request/result bundle for the iterative inverse pLayer.
interface player_inv_if #(
  parameter int WIDTH = 264
);
  logic [WIDTH-1:0] state_in;
  logic             enable;
  logic [WIDTH-1:0] state_out;
  logic             output_rdy;
  logic             busy;

  modport master (
    output state_in, enable,
    input  state_out, output_rdy, busy
  );

  modport slave (
    input  state_in, enable,
    output state_out, output_rdy, busy
  );
endinterface

// File: rtl/player_inv_mux.sv
// Selects one output chunk of the inverse permutation: chunk k bit b = src[P(CHUNK*k+b)].
module player_inv_mux
  import player_inv_pkg::*;
#(
  parameter int WIDTH = STATE_WIDTH,
  parameter int CHUNK = CHUNK_WIDTH
) (
  input  logic [WIDTH-1:0] src,
  input  logic [5:0]       k,
  output logic [CHUNK-1:0] chunk
);

  localparam int N_CHUNKS = WIDTH / CHUNK;

  logic [N_CHUNKS-1:0][CHUNK-1:0] perm;

  // Pure wiring: every tap is a constant index, so only the k-select costs logic.
  for (genvar c = 0; c < N_CHUNKS; c++) begin : g_chunk
    for (genvar b = 0; b < CHUNK; b++) begin : g_bit
      assign perm[c][b] = src[p_index(c * CHUNK + b, WIDTH)];
    end
  end

  always_comb begin
    chunk = '0;
    if (k < 6'(N_CHUNKS)) chunk = perm[k];
  end

endmodule

// File: rtl/player_inv.sv
// Iterative inverse Spongent pLayer: latches a permuted state and rebuilds the original order one chunk per clock.
module player_inv
  import player_inv_pkg::*;
#(
  parameter int WIDTH = STATE_WIDTH,
  parameter int CHUNK = CHUNK_WIDTH
) (
  input logic         clk,
  input logic         rst,
  player_inv_if.slave bus
);

  localparam int         N_CHUNKS = WIDTH / CHUNK;
  localparam logic [5:0] LAST_K   = 6'(N_CHUNKS - 1);

  inv_state_t       state;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] dst;
  logic [WIDTH-1:0] dst_next;
  logic [5:0]       k;
  logic [CHUNK-1:0] chunk;
  logic [WIDTH-1:0] state_out_q;
  logic             output_rdy_q;
  logic             busy_q;

  player_inv_mux #(
    .WIDTH(WIDTH),
    .CHUNK(CHUNK)
  ) u_mux (
    .src  (src),
    .k    (k),
    .chunk(chunk)
  );

  // The finishing edge must publish dst including the chunk it is writing right now.
  always_comb begin
    dst_next = dst;
    dst_next[CHUNK*k +: CHUNK] = chunk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      src          <= '0;
      dst          <= '0;
      k            <= '0;
      state_out_q  <= '0;
      output_rdy_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      output_rdy_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.enable) begin
            src    <= bus.state_in;
            k      <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          dst <= dst_next;
          if (k == LAST_K) begin
            state_out_q  <= dst_next;
            output_rdy_q <= 1'b1;
            busy_q       <= 1'b0;
            state        <= IDLE;
          end else begin
            k <= k + 6'd1;
          end
        end
      endcase
    end
  end

  assign bus.state_out  = state_out_q;
  assign bus.output_rdy = output_rdy_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_player_inv.sv
// Randomized self-checking bench for player_inv against a bit-routing model of pLayer and its inverse.
module tb_player_inv;
  import player_inv_pkg::*;

  localparam int W = 264;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  player_inv_if #(.WIDTH(W)) bus ();

  player_inv #(
    .WIDTH(W),
    .CHUNK(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Input bit i lands on output bit 4*i mod 263 (top bit fixed).
  function automatic logic [W-1:0] inv_model(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = '0;
    for (int i = 0; i < W; i++) y[(i == W - 1) ? W - 1 : (4 * i) % (W - 1)] = x[i];
    return y;
  endfunction

  function automatic logic [W-1:0] fwd_model(input logic [W-1:0] x);
    logic [W-1:0] y;
    y = '0;
    for (int i = 0; i < W; i++) y[(i == W - 1) ? W - 1 : (66 * i) % (W - 1)] = x[i];
    return y;
  endfunction

  function automatic logic [W-1:0] rand_state();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] bit_vec(input int n);
    logic [W-1:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Transaction-level model: one result per accept, 33 edges later, enable ignored while busy.
  logic         m_busy, m_rdy;
  logic [W-1:0] m_out, m_exp;
  int           m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_rdy  <= 1'b0;
      m_out  <= '0;
      m_exp  <= '0;
      m_left <= 0;
    end else begin
      m_rdy <= 1'b0;
      if (!m_busy) begin
        if (bus.enable) begin
          m_busy <= 1'b1;
          m_left <= 33;
          m_exp  <= inv_model(bus.state_in);
        end
      end else if (m_left == 1) begin
        m_busy <= 1'b0;
        m_rdy  <= 1'b1;
        m_out  <= m_exp;
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check_output("cmp_busy", W'(bus.busy), W'(m_busy));
      check_output("cmp_rdy", W'(bus.output_rdy), W'(m_rdy));
      check_output("cmp_state_out", bus.state_out, m_out);
    end
  end

  // Drives one accept; returns at the negedge just after the accepting edge.
  task automatic apply_stimulus(input logic [W-1:0] x);
    @(negedge clk);
    bus.state_in = x;
    bus.enable   = 1'b1;
    @(negedge clk);
    bus.enable   = 1'b0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!bus.output_rdy && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] exp);
    int lat;
    apply_stimulus(x);
    wait_rdy(lat);
    check_output({name, "_latency"}, W'(lat), W'(33));
    check_output(name, bus.state_out, exp);
    @(negedge clk);
    check_output({name, "_rdy_width"}, W'(bus.output_rdy), W'(0));
  endtask

  initial begin
    logic [W-1:0] a, b, x, got;
    int           lat, pulses, c1, c2, n;

    rst          = 1'b1;
    bus.enable   = 1'b0;
    bus.state_in = '0;
    repeat (3) @(negedge clk);
    check_output("reset_state_out", bus.state_out, '0);
    check_output("reset_busy", W'(bus.busy), W'(0));
    check_output("reset_rdy", W'(bus.output_rdy), W'(0));
    rst = 1'b0;

    check_output("model_bit1", inv_model(bit_vec(1)), bit_vec(4));
    check_output("model_bit70", inv_model(bit_vec(70)), bit_vec(17));
    check_output("model_fwd_bit1", fwd_model(bit_vec(1)), bit_vec(66));

    run_op("bit1", bit_vec(1), bit_vec(4));
    run_op("bit70", bit_vec(70), bit_vec(17));
    run_op("bit263", bit_vec(263), bit_vec(263));
    run_op("bit0", bit_vec(0), bit_vec(0));
    run_op("zeros", '0, '0);
    run_op("ones", '1, '1);

    x = '0;
    for (int i = 0; i < 33; i++) x[(32 - i)*8 +: 8] = 8'(i);
    run_op("roundtrip_bytes", fwd_model(x), x);
    for (int t = 0; t < 100; t++) begin
      x = rand_state();
      run_op("roundtrip_rand", fwd_model(x), x);
    end

    a = rand_state();
    b = rand_state();
    apply_stimulus(a);
    pulses = 0;
    got    = '0;
    for (int i = 1; i <= 45; i++) begin
      bus.enable   = (i == 5 || i == 20);
      bus.state_in = (i == 5 || i == 20) ? b : a;
      @(negedge clk);
      if (bus.output_rdy) begin
        pulses++;
        got = bus.state_out;
      end
    end
    bus.enable = 1'b0;
    check_output("enable_ignored_pulses", W'(pulses), W'(1));
    check_output("enable_ignored_result", got, inv_model(a));

    a = rand_state();
    @(negedge clk);
    bus.state_in = a;
    bus.enable   = 1'b1;
    c1 = -1;
    c2 = -1;
    n  = 0;
    while (c2 < 0 && n < 120) begin
      @(negedge clk);
      n++;
      if (bus.output_rdy) begin
        if (c1 < 0) c1 = cyc;
        else        c2 = cyc;
      end
    end
    bus.enable = 1'b0;
    check_output("held_enable_spacing", W'(c2 - c1), W'(34));
    check_output("held_enable_result", bus.state_out, inv_model(a));
    n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end

    a = rand_state();
    apply_stimulus(a);
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_state_out", bus.state_out, '0);
    check_output("async_rst_busy", W'(bus.busy), W'(0));
    check_output("async_rst_rdy", W'(bus.output_rdy), W'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.output_rdy) pulses++;
    end
    check_output("rst_no_rdy", W'(pulses), W'(0));
    b = rand_state();
    run_op("after_rst", b, inv_model(b));

    a = rand_state();
    apply_stimulus(a);
    lat = 0;
    while (!bus.output_rdy && lat < 100) begin
      bus.state_in = ~bus.state_in ^ rand_state();
      @(negedge clk);
      lat++;
    end
    check_output("toggle_latency", W'(lat), W'(33));
    check_output("toggle_result", bus.state_out, inv_model(a));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
